flit_packetizer: RTL and testbench
==================================

FLIT_PACKETIZER -- requirements
Module: flit_packetizer

Interface
REQ-001 SHALL have parameter DEVICE_TYPE, default "MASTER"; "MASTER" emits on VC 1 (requests), "SLAVE" on VC 0 (responses).
REQ-002 SHALL have parameter MAX_FLITS, default 4; maximum flits per packet, power of two, at least 2.
REQ-003 SHALL have parameter DATA_WIDTH, default `FLIT_DATA_WIDTH; payload bits per flit.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 pkt_data  input  MAX_FLITS*DATA_WIDTH  packet payload; flit i = pkt_data[i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 pkt_len  input  $clog2(MAX_FLITS)  flit count minus 1 (0 = single flit).
REQ-008 pkt_dest  input  `DEST_BITS  destination node.
REQ-009 pkt_valid  input  1  packet offered.
REQ-010 pkt_ready  output  1  packet accepted when pkt_valid && pkt_ready.
REQ-011 put_flit  output  `FLIT_WIDTH  flit toward the network input-port FIFO.
REQ-012 put_flit_valid  output  1  put_flit valid.
REQ-013 put_flit_ready  input  1  downstream FIFO accepts put_flit this cycle.
REQ-014 pkt_sent_count  output  16  count of completed packets; wraps.

Function
REQ-015 SHALL pack put_flit MSB to LSB as {valid, tail, dest, vc, data}: valid = put_flit_valid, tail = 1 on last flit only, dest = latched pkt_dest, vc = VC from REQ-001 zero-extended to `VC_BITS, data = current payload slice.
REQ-016 SHALL use states IDLE and SEND.
REQ-017 In IDLE: pkt_ready = 1, put_flit_valid = 0. On accept: latch pkt_data, pkt_len and pkt_dest; clear flit index to 0; go to SEND next cycle.
REQ-018 In SEND: put_flit_valid = 1; each cycle with put_flit_ready = 1 sends flit[index], then index increments.
REQ-019 Flit transfer happens only when put_flit_valid && put_flit_ready; with put_flit_ready = 0, put_flit SHALL hold stable and index is unchanged.
REQ-020 Tail flit is the one with index == latched pkt_len; its transfer SHALL increment pkt_sent_count by 1.
REQ-021 In SEND, pkt_ready SHALL equal (index == latched pkt_len) && put_flit_ready; the block never combinationally depends on pkt_valid.
REQ-022 Tail transfer with a simultaneous new accept (back-to-back): latch the new packet, set index to 0, stay in SEND; no idle bubble.
REQ-023 Tail transfer without a new accept: go to IDLE.
REQ-024 Latency: first flit valid exactly one cycle after accept; sustained rate 1 flit/cycle while put_flit_ready = 1.
REQ-025 pkt_len values at or above MAX_FLITS cannot occur, by width.
REQ-026 pkt_sent_count SHALL wrap from 16'hFFFF to 0.
REQ-027 put_flit valid bit is 0 whenever put_flit_valid = 0; data/dest fields are don't-care then.

Reset
REQ-028 RST_N low SHALL immediately force: state IDLE, index 0, pkt_sent_count 0, put_flit_valid 0, put_flit 0, pkt_ready 0 while asserted.
REQ-029 After RST_N deasserts, pkt_ready = 1 from the first clock edge.
REQ-030 Reset mid-packet SHALL discard remaining flits; no partial tail is emitted after reset.

Verification (MAX_FLITS=4, DATA_WIDTH=32, MASTER)
REQ-031 Single flit: pkt_len=0, dest=3, data[31:0]=0xA5A5A5A5, ready held 1 -> next cycle one flit with valid=1, tail=1, dest=3, vc=1, data=0xA5A5A5A5; pkt_sent_count=1; IDLE.
REQ-032 Four flits: pkt_len=3, words 0x11,0x22,0x33,0x44 -> four consecutive flits in that order, tail only on 0x44, pkt_ready=1 in the tail cycle.
REQ-033 Backpressure: put_flit_ready=0 for 3 cycles during flit 2 of 4 -> flit 2 held stable and repeated, no loss or duplication at transfers, total 4 transfers.
REQ-034 Back-to-back: second packet pkt_len=1 presented during first packet's tail -> accepted that cycle; its flit 0 follows in the next cycle; count increments by 2 total.
REQ-035 Async reset: RST_N dropped between clock edges mid-packet -> put_flit_valid=0 without a clock edge; after release, pkt_ready=1 and pkt_sent_count=0.
REQ-036 SLAVE instance: any packet -> vc field = 0; 65536 single-flit packets -> pkt_sent_count returns to 0.

Source files
------------

// File: rtl/flit_packetizer.sv
// flit_packetizer: cuts a packet of up to MAX_FLITS payload words into
// flits tagged {valid, tail, dest, vc, data} for a NoC input-port FIFO.
// Ports: CLK/RST_N; pkt_* packet in (valid/ready); put_flit* flit out
// (valid/ready); pkt_sent_count counts completed packets.

`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif
`ifndef DEST_BITS
`define DEST_BITS 4
`endif
`ifndef VC_BITS
`define VC_BITS 2
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH (2 + `DEST_BITS + `VC_BITS + `FLIT_DATA_WIDTH)
`endif

module flit_packetizer #(
  parameter     DEVICE_TYPE = "MASTER",
  parameter int MAX_FLITS   = 4,
  parameter int DATA_WIDTH  = `FLIT_DATA_WIDTH
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [MAX_FLITS*DATA_WIDTH-1:0] pkt_data,
  input  logic [$clog2(MAX_FLITS)-1:0]    pkt_len,
  input  logic [`DEST_BITS-1:0]           pkt_dest,
  input  logic                            pkt_valid,
  output logic                            pkt_ready,
  output logic [DATA_WIDTH+`DEST_BITS+`VC_BITS+1:0] put_flit,
  output logic                            put_flit_valid,
  input  logic                            put_flit_ready,
  output logic [15:0]                     pkt_sent_count
);

  localparam int LW = $clog2(MAX_FLITS);

  // Requests travel on VC 1, responses on VC 0.
  localparam logic [`VC_BITS-1:0] VC =
    (DEVICE_TYPE == "MASTER") ? {{(`VC_BITS-1){1'b0}}, 1'b1} : '0;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state;
  logic [LW-1:0]                   idx;
  logic [LW-1:0]                   len_q;
  logic [`DEST_BITS-1:0]           dest_q;
  logic [MAX_FLITS*DATA_WIDTH-1:0] data_q;
  logic                            live;
  logic                            last;
  logic                            fire;
  logic                            accept;
  logic [DATA_WIDTH-1:0]           slice;

  assign last           = (idx == len_q);
  assign put_flit_valid = (state == SEND);
  assign fire           = put_flit_valid && put_flit_ready;

  // live holds ready low through reset and until the first edge after it.
  // In SEND a new packet is only taken alongside the tail transfer.
  assign pkt_ready = live &&
                     ((state == IDLE) || (last && put_flit_ready));
  assign accept    = pkt_valid && pkt_ready;

  assign slice    = data_q[idx*DATA_WIDTH +: DATA_WIDTH];
  assign put_flit = put_flit_valid ? {1'b1, last, dest_q, VC, slice} : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      idx            <= '0;
      len_q          <= '0;
      dest_q         <= '0;
      data_q         <= '0;
      pkt_sent_count <= '0;
      live           <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            data_q <= pkt_data;
            len_q  <= pkt_len;
            dest_q <= pkt_dest;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            if (last) begin
              pkt_sent_count <= pkt_sent_count + 16'd1;
              if (accept) begin
                data_q <= pkt_data;
                len_q  <= pkt_len;
                dest_q <= pkt_dest;
                idx    <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flit_packetizer.sv
// tb_flit_packetizer: directed and randomized checks of flit_packetizer
// (MASTER and SLAVE instances, 4 flits x 32 bits).

module tb_flit_packetizer;

  localparam int DW = 32;
  localparam int MF = 4;
  localparam int DB = 4;
  localparam int VB = 2;
  localparam int FW = 2 + DB + VB + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [MF*DW-1:0] m_data, s_data;
  logic [1:0]       m_len, s_len;
  logic [DB-1:0]    m_dest, s_dest;
  logic             m_valid, s_valid;
  logic             m_ready, s_ready;
  logic [FW-1:0]    m_flit, s_flit;
  logic             m_fv, s_fv;
  logic             m_fr, s_fr;
  logic [15:0]      m_cnt, s_cnt;

  flit_packetizer #(
    .DEVICE_TYPE("MASTER"), .MAX_FLITS(MF), .DATA_WIDTH(DW)
  ) u_m (
    .CLK(clk), .RST_N(rst_n),
    .pkt_data(m_data), .pkt_len(m_len), .pkt_dest(m_dest),
    .pkt_valid(m_valid), .pkt_ready(m_ready),
    .put_flit(m_flit), .put_flit_valid(m_fv),
    .put_flit_ready(m_fr), .pkt_sent_count(m_cnt)
  );

  flit_packetizer #(
    .DEVICE_TYPE("SLAVE"), .MAX_FLITS(MF), .DATA_WIDTH(DW)
  ) u_s (
    .CLK(clk), .RST_N(rst_n),
    .pkt_data(s_data), .pkt_len(s_len), .pkt_dest(s_dest),
    .pkt_valid(s_valid), .pkt_ready(s_ready),
    .put_flit(s_flit), .put_flit_valid(s_fv),
    .put_flit_ready(s_fr), .pkt_sent_count(s_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [MF*DW-1:0] d;
    logic [1:0]       l;
    logic [DB-1:0]    dst;
  } pkt_t;

  pkt_t          acc[$];
  logic [FW-1:0] got[$];
  int            stall_bad = 0;
  logic          stalled = 1'b0;
  logic [FW-1:0] held = '0;

  // Record handshakes mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_fv && stalled && (m_flit !== held)) stall_bad++;
      if (m_valid && m_ready) acc.push_back('{m_data, m_len, m_dest});
      if (m_fv && m_fr) got.push_back(m_flit);
      stalled <= m_fv && !m_fr;
      held    <= m_flit;
    end else begin
      stalled <= 1'b0;
    end
  end

  function automatic logic [FW-1:0] mk(input logic tail,
                                       input logic [DB-1:0] d,
                                       input logic [VB-1:0] vc,
                                       input logic [DW-1:0] w);
    return {1'b1, tail, d, vc, w};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [MF*DW-1:0] a_data;
  logic [FW-1:0]    exp_q[$];

  initial begin
    m_data = '0; m_len = '0; m_dest = '0; m_valid = 0; m_fr = 0;
    s_data = '0; s_len = '0; s_dest = '0; s_valid = 0; s_fr = 0;

    // reset state
    #3;
    chk("rst_fv", m_fv, 0);
    chk("rst_flit", m_flit, 0);
    chk("rst_rdy", m_ready, 0);
    chk("rst_cnt", m_cnt, 0);
    tick();
    chk("rst_rdy_edge", m_ready, 0);
    rst_n = 1;
    tick();
    chk("rel_rdy", m_ready, 1);

    // single flit
    m_len = 0; m_dest = 3; m_data = '0;
    m_data[31:0] = 32'hA5A5A5A5;
    m_fr = 1; m_valid = 1;
    #1;
    chk("t1_idle_rdy", m_ready, 1);
    tick();
    m_valid = 0;
    #1;
    chk("t1_fv", m_fv, 1);
    chk("t1_flit", m_flit, mk(1, 3, 1, 32'hA5A5A5A5));
    chk("t1_tail_rdy", m_ready, 1);
    tick();
    chk("t1_cnt", m_cnt, 1);
    chk("t1_idle", m_fv, 0);

    // four flits, ready held
    m_data = {32'h44, 32'h33, 32'h22, 32'h11};
    m_len = 3; m_dest = 5; m_valid = 1;
    tick();
    m_valid = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_flit", m_flit, mk(i == 3, 5, 1, m_data[i*DW +: DW]));
      chk("t2_rdy", m_ready, (i == 3) ? 1 : 0);
      tick();
    end
    chk("t2_cnt", m_cnt, 2);
    chk("t2_idle", m_fv, 0);

    // backpressure on flit 2
    got.delete();
    m_data = {$urandom, $urandom, $urandom, $urandom};
    m_len = 3; m_dest = 9; m_valid = 1;
    tick();
    m_valid = 0;
    tick();
    tick();
    m_fr = 0;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("t3_hold", m_flit, mk(0, 9, 1, m_data[2*DW +: DW]));
      chk("t3_rdy", m_ready, 0);
      tick();
    end
    m_fr = 1;
    #1;
    chk("t3_resume", m_flit, mk(0, 9, 1, m_data[2*DW +: DW]));
    tick();
    tick();
    chk("t3_xfers", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t3_seq", got[i], mk(i == 3, 9, 1, m_data[i*DW +: DW]));
    chk("t3_stable", stall_bad, 0);
    chk("t3_cnt", m_cnt, 3);

    // back-to-back packets
    m_data = {$urandom, $urandom, $urandom, $urandom};
    a_data = m_data;
    m_len = 2; m_dest = 1; m_valid = 1;
    tick();
    m_valid = 0;
    tick();
    tick();
    m_data = {$urandom, $urandom, $urandom, $urandom};
    m_len = 1; m_dest = 7; m_valid = 1;
    #1;
    chk("t4_rdy", m_ready, 1);
    chk("t4_atail", m_flit, mk(1, 1, 1, a_data[2*DW +: DW]));
    tick();
    m_valid = 0;
    #1;
    chk("t4_nobubble", m_fv, 1);
    chk("t4_b0", m_flit, mk(0, 7, 1, m_data[0 +: DW]));
    tick();
    chk("t4_b1", m_flit, mk(1, 7, 1, m_data[DW +: DW]));
    tick();
    chk("t4_cnt", m_cnt, 5);
    chk("t4_idle", m_fv, 0);

    // async reset mid-packet
    m_len = 3; m_dest = 2; m_valid = 1;
    tick();
    m_valid = 0;
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("t5_fv", m_fv, 0);
    chk("t5_flit", m_flit, 0);
    chk("t5_rdy", m_ready, 0);
    chk("t5_cnt", m_cnt, 0);
    tick();
    rst_n = 1;
    #1;
    chk("t5_rel_fv", m_fv, 0);
    tick();
    chk("t5_rel_rdy", m_ready, 1);
    chk("t5_no_tail", m_fv, 0);
    chk("t5_rel_cnt", m_cnt, 0);

    // randomized traffic against the packet-level model
    acc.delete();
    got.delete();
    stall_bad = 0;
    for (int k = 0; k < 150; k++) begin
      int  w;
      bit  done;
      w = 0;
      done = 0;
      m_data  = {$urandom, $urandom, $urandom, $urandom};
      m_len   = 2'($urandom);
      m_dest  = 4'($urandom);
      m_valid = 1;
      while (!done && w <= 40) begin
        m_fr = ($urandom % 4) != 0;
        #1;
        done = m_ready;
        tick();
        w++;
      end
      chk("rnd_accept", done, 1);
      m_valid = 0;
      if ($urandom % 3 == 0) begin
        m_fr = 1'($urandom);
        tick();
      end
    end
    m_fr = 1;
    repeat (6) tick();
    foreach (acc[p])
      for (int i = 0; i <= int'(acc[p].l); i++)
        exp_q.push_back(mk(i == int'(acc[p].l), acc[p].dst, 1,
                           acc[p].d[i*DW +: DW]));
    chk("rnd_pkts", acc.size(), 150);
    chk("rnd_nflits", got.size(), exp_q.size());
    foreach (exp_q[i])
      chk("rnd_flit", got[i], exp_q[i]);
    chk("rnd_stable", stall_bad, 0);
    chk("rnd_cnt", m_cnt, 16'(acc.size()));
    chk("rnd_idle", m_fv, 0);

    // slave: vc 0, counter wrap over 65536 packets
    s_len = 0; s_dest = 4'hA;
    s_data = {$urandom, $urandom, $urandom, $urandom};
    s_fr = 1; s_valid = 1;
    tick();
    #1;
    chk("s_fv", s_fv, 1);
    chk("s_vc", s_flit[DW +: VB], 0);
    chk("s_flit", s_flit, mk(1, 4'hA, 0, s_data[0 +: DW]));
    repeat (65535) tick();
    chk("s_cnt_max", s_cnt, 16'hFFFF);
    s_valid = 0;
    tick();
    chk("s_cnt_wrap", s_cnt, 0);
    chk("s_idle", s_fv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
